// File: rtl/sonar_scheduler_if.sv
// rtl/sonar_scheduler_if.sv - sensor pins and measurement report bundle for sonar_scheduler
interface sonar_scheduler_if #(
    parameter int NUM_SENSORS = 3
);
    logic [NUM_SENSORS-1:0]    echo;
    logic [NUM_SENSORS-1:0]    trig;
    logic [16*NUM_SENSORS-1:0] dist_flat;
    logic [NUM_SENSORS-1:0]    valid;
    logic                      meas_done;
    logic [1:0]                meas_id;
    logic                      meas_ok;
    logic [15:0]               meas_raw_cm;
    logic                      busy;

    modport master (
        input  echo,
        output trig, dist_flat, valid, meas_done, meas_id, meas_ok, meas_raw_cm, busy
    );

    modport slave (
        output echo,
        input  trig, dist_flat, valid, meas_done, meas_id, meas_ok, meas_raw_cm, busy
    );
endinterface

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - one-at-a-time HC-SR04 scheduler; SONAR_FRONT_PRIORITY_EN interleaves sensor 0
module sonar_scheduler #(
    parameter int NUM_SENSORS     = 3,
    parameter int TRIG_US         = 10,
    parameter int ECHO_TIMEOUT_US = 30000,
    parameter int GUARD_US        = 10000,
    parameter int US_PER_CM       = 58,
    parameter int MIN_CM          = 2,
    parameter int MAX_CM          = 400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_us,
    input  logic              enable,
    sonar_scheduler_if.master bus
);
    localparam int SUBW = $clog2(US_PER_CM + 1);
    localparam logic [1:0]             LAST      = 2'(NUM_SENSORS - 1);
    localparam logic [15:0]            TRIG_END  = 16'(TRIG_US - 1);
    localparam logic [15:0]            TMO_END   = 16'(ECHO_TIMEOUT_US - 1);
    localparam logic [15:0]            GUARD_END = 16'(GUARD_US - 1);
    localparam logic [SUBW-1:0]        SUB_END   = SUBW'(US_PER_CM - 1);
    localparam logic [NUM_SENSORS-1:0] ONE       = NUM_SENSORS'(1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GUARD} state_t;

    state_t                 state;
    logic [NUM_SENSORS-1:0] echo_s1, echo_s2, echo_s3;
    logic [15:0]            timer, cm;
    logic [SUBW-1:0]        sub;
    logic [1:0]             sel, next_sel;
    logic                   timed_out;
    logic                   echo_rise, echo_fall, in_range, guard_done;

    assign echo_rise  = echo_s2[sel] & ~echo_s3[sel];
    assign echo_fall  = ~echo_s2[sel] & echo_s3[sel];
    assign in_range   = !timed_out && (cm >= 16'(MIN_CM)) && (cm <= 16'(MAX_CM));
    assign guard_done = (state == GUARD) && tick_us && (timer == GUARD_END);

`ifdef SONAR_FRONT_PRIORITY_EN
    // side remembers which non-front sensor follows the next front slot
    logic [1:0] side;

    always_comb begin
        next_sel = (sel == 2'd0) ? side : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            side <= 2'd1;
        end else if (guard_done && sel != 2'd0) begin
            side <= (side == LAST) ? 2'd1 : side + 2'd1;
        end
    end
`else
    always_comb begin
        next_sel = (sel == LAST) ? 2'd0 : sel + 2'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            echo_s1         <= '0;
            echo_s2         <= '0;
            echo_s3         <= '0;
            timer           <= '0;
            cm              <= '0;
            sub             <= '0;
            sel             <= '0;
            timed_out       <= 1'b0;
            bus.trig        <= '0;
            bus.dist_flat   <= '0;
            bus.valid       <= '0;
            bus.meas_done   <= 1'b0;
            bus.meas_id     <= '0;
            bus.meas_ok     <= 1'b0;
            bus.meas_raw_cm <= '0;
            bus.busy        <= 1'b0;
        end else begin
            echo_s1       <= bus.echo;
            echo_s2       <= echo_s1;
            echo_s3       <= echo_s2;
            bus.meas_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= TRIG;
                        bus.trig  <= ONE << sel;
                        bus.busy  <= 1'b1;
                        timer     <= '0;
                        timed_out <= 1'b0;
                    end
                end
                TRIG: begin
                    if (tick_us) begin
                        if (timer == TRIG_END) begin
                            bus.trig <= '0;
                            timer    <= '0;
                            state    <= WAIT_RISE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                WAIT_RISE: begin
                    // an edge wins over a coincident tick, which is then dropped
                    if (echo_rise) begin
                        sub   <= '0;
                        cm    <= '0;
                        timer <= '0;
                        state <= MEASURE;
                    end else if (tick_us) begin
                        if (timer == TMO_END) begin
                            timed_out <= 1'b1;
                            state     <= REPORT;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        state <= REPORT;
                    end else if (tick_us) begin
                        if (sub == SUB_END) begin
                            sub <= '0;
                            cm  <= (cm == 16'hFFFF) ? cm : cm + 16'd1;
                        end else begin
                            sub <= sub + SUBW'(1);
                        end
                        if (timer == TMO_END) begin
                            timed_out <= 1'b1;
                            state     <= REPORT;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                REPORT: begin
                    bus.meas_done   <= 1'b1;
                    bus.meas_id     <= sel;
                    bus.meas_raw_cm <= timed_out ? 16'hFFFF : cm;
                    bus.meas_ok     <= in_range;
                    bus.valid[sel]  <= in_range;
                    if (in_range) begin
                        bus.dist_flat[16*sel +: 16] <= cm;
                    end
                    timer <= '0;
                    state <= GUARD;
                end
                GUARD: begin
                    if (tick_us) begin
                        if (timer == GUARD_END) begin
                            sel       <= next_sel;
                            timer     <= '0;
                            timed_out <= 1'b0;
                            if (enable) begin
                                bus.trig <= ONE << next_sel;
                                state    <= TRIG;
                            end else begin
                                bus.busy <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
